// File: rtl/handshake_pkg.sv
// handshake_pkg: definitions shared by the handshake pipeline blocks.
//   L_DEFAULT      default data width in bits
//   DEPTH_DEFAULT  default FIFO depth (entries)
//   ptr_width()    pointer width for a given depth ($clog2 wrapper)
//   xfer_e         push/pop enable encoding, the same naming the
//                  forward/backward pipe stages use
package handshake_pkg;

    localparam int L_DEFAULT     = 8;
    localparam int DEPTH_DEFAULT = 4;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // {push, pop} packed into a single two-bit code.
    typedef enum logic [1:0] {
        XFER_NONE = 2'b00,
        XFER_POP  = 2'b01,
        XFER_PUSH = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

endpackage

// File: rtl/hs_fifo_mem.sv
// hs_fifo_mem: DEPTH x L register array for hs_fifo_stage.
//   clk    rising-edge clock
//   we     write enable (synchronous write)
//   waddr  write address
//   wdata  write data
//   raddr  read address (asynchronous read)
//   rdata  read data, combinational from raddr
// Contents are not reset; the owner of the pointers decides what is valid.
module hs_fifo_mem #(
    parameter int L     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [L-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [L-1:0]  rdata
);

    logic [L-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hs_fifo_stage.sv
// hs_fifo_stage: synchronous first-word-fall-through FIFO between two
// valid/ready interfaces.
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   valid_f      upstream word valid
//   ready_f      FIFO can accept a word (registered, never depends on ready_b)
//   data_f       upstream word
//   valid_b      FIFO holds a word for downstream (registered)
//   ready_b      downstream accepts this cycle
//   data_b       head-of-FIFO word, meaningful only while valid_b=1
//   count        occupancy, 0..DEPTH
//   almost_full  registered, count >= AF_LEVEL
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side (push = valid_f && ready_f, pop = valid_b && ready_b).
// The sender may not retract a word before it is taken, but the FIFO never
// relies on that; while valid_b && !ready_b the head word is held stable.
module hs_fifo_stage
    import handshake_pkg::*;
#(
    parameter int L        = L_DEFAULT,
    parameter int DEPTH    = DEPTH_DEFAULT,
    parameter int AF_LEVEL = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_f,
    output logic                       ready_f,
    input  logic [L-1:0]               data_f,
    output logic                       valid_b,
    input  logic                       ready_b,
    output logic [L-1:0]               data_b,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;

    logic  push;
    logic  pop;
    xfer_e op;

    always_comb begin
        push     = valid_f && !full_q;
        pop      = !empty_q && ready_b;
        op       = xfer_e'({push, pop});
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        case (op)
            XFER_PUSH: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                count_d  = count_q + CNT_ONE;
            end
            XFER_POP: begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                count_d  = count_q - CNT_ONE;
            end
            XFER_BOTH: begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            default: ;
        endcase

        // Flags are computed from the next count so they are registered
        // alongside it and change in the same cycle as count.
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
        af_d    = (count_d >= AF_C);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // Held "full" during reset so ready_f stays low until the first
            // edge that samples rst high.
            full_q   <= 1'b1;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
        end
    end

    hs_fifo_mem #(
        .L     (L),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (data_f),
        .raddr (rd_ptr_q),
        .rdata (data_b)
    );

    assign ready_f     = !full_q;
    assign valid_b     = !empty_q;
    assign count       = count_q;
    assign almost_full = af_q;

endmodule

// File: tb/tb_hs_fifo_stage.sv
// tb_hs_fifo_stage: directed self-checking bench for hs_fifo_stage
// (L=8, DEPTH=4, AF_LEVEL=3). Inputs change 1 time unit after each rising
// edge; outputs are checked at the same point, before new inputs are applied.
module tb_hs_fifo_stage;

    logic       clk;
    logic       rst;
    logic       valid_f;
    logic       ready_f;
    logic [7:0] data_f;
    logic       valid_b;
    logic       ready_b;
    logic [7:0] data_b;
    logic [2:0] count;
    logic       almost_full;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];

    hs_fifo_stage #(
        .L        (8),
        .DEPTH    (4),
        .AF_LEVEL (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_f     (valid_f),
        .ready_f     (ready_f),
        .data_f      (data_f),
        .valid_b     (valid_b),
        .ready_b     (ready_b),
        .data_b      (data_b),
        .count       (count),
        .almost_full (almost_full)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; valid_f = 1'b0; ready_b = 1'b0; data_f = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (ready_f !== 1'b0) begin n_err++; $display("FAIL reset_ready_f: got %b exp 0", ready_f); end
            n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL reset_valid_b: got %b exp 0", valid_b); end
            n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", count); end
            n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af: got %b exp 0", almost_full); end
        end
        rst = 1'b1;
        tick();
        n_cmp++; if (ready_f !== 1'b1) begin n_err++; $display("FAIL release_ready_f: got %b exp 1", ready_f); end
        n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL release_valid_b: got %b exp 0", valid_b); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL release_count: got %0d exp 0", count); end
    endtask

    task automatic test_single();
        ready_b = 1'b0; valid_f = 1'b1; data_f = 8'hA5;
        tick();
        valid_f = 1'b0;
        n_cmp++; if (valid_b !== 1'b1) begin n_err++; $display("FAIL single_valid_b: got %b exp 1", valid_b); end
        n_cmp++; if (data_b !== 8'hA5) begin n_err++; $display("FAIL single_data_b: got %h exp a5", data_b); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count: got %0d exp 1", count); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL single_af: got %b exp 0", almost_full); end
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL single_drain_valid_b: got %b exp 0", valid_b); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_drain_count: got %0d exp 0", count); end
    endtask

    task automatic test_fill();
        ready_b = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            valid_f = 1'b1; data_f = 8'(i);
            tick();
            n_cmp++; if (count !== 3'(i)) begin n_err++; $display("FAIL fill_count: got %0d exp %0d", count, i); end
            n_cmp++; if (almost_full !== (i >= 3)) begin n_err++; $display("FAIL fill_af: got %b exp %b at count %0d", almost_full, (i >= 3), i); end
            n_cmp++; if (ready_f !== (i != 4)) begin n_err++; $display("FAIL fill_ready_f: got %b exp %b at count %0d", ready_f, (i != 4), i); end
        end
        // fifth word held while full must be refused
        data_f = 8'h05;
        tick();
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_hold_count: got %0d exp 4", count); end
        n_cmp++; if (data_b !== 8'h01) begin n_err++; $display("FAIL full_head: got %h exp 01", data_b); end
        // drain; ready_f returns one cycle after the first pop
        ready_b = 1'b1;
        tick();
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL drain1_count: got %0d exp 3", count); end
        n_cmp++; if (ready_f !== 1'b1) begin n_err++; $display("FAIL drain1_ready_f: got %b exp 1", ready_f); end
        n_cmp++; if (data_b !== 8'h02) begin n_err++; $display("FAIL drain1_data: got %h exp 02", data_b); end
        n_cmp++; if (almost_full !== 1'b1) begin n_err++; $display("FAIL drain1_af: got %b exp 1", almost_full); end
        tick();
        valid_f = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL drain2_count: got %0d exp 3", count); end
        n_cmp++; if (data_b !== 8'h03) begin n_err++; $display("FAIL drain2_data: got %h exp 03", data_b); end
        tick();
        n_cmp++; if (data_b !== 8'h04) begin n_err++; $display("FAIL drain3_data: got %h exp 04", data_b); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL drain3_af: got %b exp 0", almost_full); end
        tick();
        n_cmp++; if (data_b !== 8'h05) begin n_err++; $display("FAIL drain4_data: got %h exp 05", data_b); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL drain4_count: got %0d exp 1", count); end
        tick();
        ready_b = 1'b0;
        n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL drain_empty_valid_b: got %b exp 0", valid_b); end
    endtask

    task automatic test_stream();
        ready_b = 1'b1;
        for (int i = 0; i < 16; i++) begin
            valid_f = 1'b1; data_f = 8'(i);
            tick();
            n_cmp++; if (valid_b !== 1'b1) begin n_err++; $display("FAIL stream_valid_b: got %b exp 1 at word %0d", valid_b, i); end
            n_cmp++; if (data_b !== 8'(i)) begin n_err++; $display("FAIL stream_data: got %h exp %h", data_b, 8'(i)); end
            n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL stream_count: got %0d exp 1 at word %0d", count, i); end
        end
        valid_f = 1'b0;
        tick();
        ready_b = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL stream_end_count: got %0d exp 0", count); end
        n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL stream_end_valid_b: got %b exp 0", valid_b); end
    endtask

    task automatic test_near_full();
        ready_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_f = 1'b1; data_f = 8'h30 + 8'(i);
            tick();
        end
        // push and pop together at count 3
        data_f = 8'h33; ready_b = 1'b1;
        tick();
        valid_f = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL near_full_count: got %0d exp 3", count); end
        n_cmp++; if (ready_f !== 1'b1) begin n_err++; $display("FAIL near_full_ready_f: got %b exp 1", ready_f); end
        n_cmp++; if (data_b !== 8'h31) begin n_err++; $display("FAIL near_full_data: got %h exp 31", data_b); end
        for (int i = 0; i < 3; i++) tick();
        ready_b = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL near_full_drain: got %0d exp 0", count); end
    endtask

    task automatic test_wrap_random();
        int sent = 0;
        int recv = 0;
        int m_count = 0;
        int cycles = 0;
        logic do_push, do_pop;
        exp_q.delete();
        valid_f = 1'b0; ready_b = 1'b0;
        while (recv < 64 && cycles < 2000) begin
            n_cmp++; if (count !== 3'(m_count)) begin n_err++; $display("FAIL wrap_count: got %0d exp %0d", count, m_count); end
            n_cmp++; if (ready_f !== (m_count != 4)) begin n_err++; $display("FAIL wrap_ready_f: got %b exp %b", ready_f, (m_count != 4)); end
            n_cmp++; if (valid_b !== (m_count != 0)) begin n_err++; $display("FAIL wrap_valid_b: got %b exp %b", valid_b, (m_count != 0)); end
            if (m_count != 0) begin
                n_cmp++; if (data_b !== exp_q[0]) begin n_err++; $display("FAIL wrap_data: got %h exp %h", data_b, exp_q[0]); end
            end
            valid_f = (sent < 64) && ($urandom_range(0, 99) < 60);
            ready_b = ($urandom_range(0, 99) < 50);
            data_f  = 8'(sent * 37 + 11);
            do_push = valid_f && (m_count != 4);
            do_pop  = ready_b && (m_count != 0);
            tick();
            cycles++;
            if (do_pop) begin
                void'(exp_q.pop_front());
                recv++;
                m_count--;
            end
            if (do_push) begin
                exp_q.push_back(data_f);
                sent++;
                m_count++;
            end
        end
        valid_f = 1'b0; ready_b = 1'b0;
        n_cmp++; if (recv != 64) begin n_err++; $display("FAIL wrap_timeout: got %0d words exp 64", recv); end
    endtask

    task automatic test_reset_mid();
        ready_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_f = 1'b1; data_f = 8'hE0 + 8'(i);
            tick();
        end
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL mid_pre_count: got %0d exp 3", count); end
        valid_f = 1'b0; rst = 1'b0;
        tick();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d exp 0", count); end
        n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid_b: got %b exp 0", valid_b); end
        n_cmp++; if (ready_f !== 1'b0) begin n_err++; $display("FAIL mid_rst_ready_f: got %b exp 0", ready_f); end
        rst = 1'b1;
        tick();
        n_cmp++; if (ready_f !== 1'b1) begin n_err++; $display("FAIL mid_release_ready_f: got %b exp 1", ready_f); end
        n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL mid_release_valid_b: got %b exp 0", valid_b); end
        valid_f = 1'b1; data_f = 8'h77;
        tick();
        valid_f = 1'b0;
        n_cmp++; if (data_b !== 8'h77) begin n_err++; $display("FAIL mid_new_data: got %h exp 77", data_b); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL mid_new_count: got %0d exp 1", count); end
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL mid_final_valid_b: got %b exp 0", valid_b); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_near_full();
        test_wrap_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
